// File: rtl/fifo_rd_stream.sv
// rtl/fifo_rd_stream.sv - FIFO read-side adapter presenting a valid/ready stream through a 2-entry skid buffer
module fifo_rd_stream #(
  parameter int width = 8,
  parameter int CNT_W = 16
) (
  input  logic             r_clk,
  input  logic             rst_r,
  input  logic             empty,
  input  logic [width-1:0] r_data,
  output logic             r_en,
  output logic [width-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [CNT_W-1:0] rd_count
);

  logic             inflight;
  logic [1:0]       occ;
  logic             wr_ptr;
  logic             rd_ptr;
  logic [width-1:0] mem [2];
  logic             pop;
  logic [2:0]       space;

  // A slot is free if it is neither occupied nor reserved by a read already in flight;
  // a pop this cycle frees a slot in time for the word that would land next cycle.
  assign pop     = m_valid && m_ready;
  assign space   = 3'd2 - {1'b0, occ} - {2'b00, inflight} + {2'b00, pop};
  assign r_en    = !rst_r && !empty && (space != 3'd0);
  assign m_valid = (occ != 2'd0);
  assign m_data  = mem[rd_ptr];

  // Remember that a read was issued so its data is captured on the next edge.
  always_ff @(posedge r_clk or posedge rst_r) begin
    if (rst_r) inflight <= 1'b0;
    else       inflight <= r_en;
  end

  // Occupancy rises on capture and falls on pop; both together leave it unchanged.
  always_ff @(posedge r_clk or posedge rst_r) begin
    if (rst_r) occ <= 2'd0;
    else       occ <= occ + {1'b0, inflight} - {1'b0, pop};
  end

  // Write pointer follows captures, read pointer follows pops.
  always_ff @(posedge r_clk or posedge rst_r) begin
    if (rst_r) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (inflight) wr_ptr <= ~wr_ptr;
      if (pop)      rd_ptr <= ~rd_ptr;
    end
  end

  // Capture the FIFO's registered read data one cycle after the strobe.
  always_ff @(posedge r_clk or posedge rst_r) begin
    if (rst_r) begin
      mem[0] <= '0;
      mem[1] <= '0;
    end else if (inflight) begin
      mem[wr_ptr] <= r_data;
    end
  end

  // Count accepted stream transfers, wrapping naturally.
  always_ff @(posedge r_clk or posedge rst_r) begin
    if (rst_r)    rd_count <= '0;
    else if (pop) rd_count <= rd_count + CNT_W'(1);
  end

  a_no_overflow: assert property (@(posedge r_clk) disable iff (rst_r)
    ({1'b0, occ} + {2'b00, inflight}) <= 3'd2);

endmodule
